bist_response_analyser: RTL

Parametrised BIST output-response analyser for the counter-under-test self-test loop. It compacts a stream of circuit responses into an on-chip MISR signature over a programmable test window. At window end it compares the signature against a golden value and reports sticky pass/fail with a done handshake. It replaces the fixed-width, fixed-length, free-running comparator with a start/abort-controlled session engine.

---
 rtl/bist_response_analyser.sv | 120 ++++++++++++
 1 files changed

// File: rtl/bist_response_analyser.sv
// BIST output-response analyser: compacts a response stream into a MISR over a
// start/abort-controlled session window and reports a sticky golden-signature verdict.
module bist_response_analyser #(
  parameter int unsigned      WIDTH    = 3,
  parameter int unsigned      TEST_LEN = 8,
  parameter logic [WIDTH-1:0] POLY     = 3'b011,
  parameter logic [WIDTH-1:0] SEED     = '0,
  parameter logic [WIDTH-1:0] GOLDEN   = 3'b010,
  localparam int unsigned     CNT_W    = $clog2(TEST_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [WIDTH-1:0] sig_out,
  output logic [CNT_W-1:0] resp_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] misr_q, misr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [WIDTH-1:0] misr_step_c;

  // State and all outputs registered; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      misr_q  <= SEED;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  // Next-state and datapath; abort overrides every other request.
  always_comb begin
    state_d     = state_q;
    misr_d      = misr_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    misr_step_c = {misr_q[WIDTH-2:0], 1'b0} ^ (misr_q[WIDTH-1] ? POLY : '0) ^ resp;

    if (abort) begin
      state_d = IDLE;
      misr_d  = SEED;
      cnt_d   = '0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = RUN;
            misr_d  = SEED;
            cnt_d   = '0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
          end
        end
        RUN: begin
          if (resp_valid) begin
            misr_d = misr_step_c;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(TEST_LEN - 1)) begin
              state_d = CHECK;
            end
          end
        end
        CHECK: begin
          pass_d  = (misr_q == GOLDEN);
          fail_d  = (misr_q != GOLDEN);
          done_d  = 1'b1;
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == RUN) || (state_d == CHECK);
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign sig_out  = misr_q;
  assign resp_cnt = cnt_q;

endmodule
